// File: rtl/led_pkg.sv
// Shared types for the LED sequencer and led_controller: step record and sequencer state.
package led_pkg;
  localparam int RGB_W = 3;
  localparam int DUR_W = 27;

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic [DUR_W-1:0] dur;
  } step_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} seq_state_t;
endpackage

// File: rtl/led_step_table.sv
// DEPTH-entry step register file: one synchronous write port, one asynchronous read port.
module led_step_table
  import led_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  step_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output step_t             rd_data
);
  // Contents are intentionally not reset; a table is always written before use.
  step_t mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/led_sequencer.sv
// Steps led_controller through a table of {rgb, duration} entries, one-shot or looping.
// Optional dark gap between steps when SEQ_GAP_EN is defined.
module led_sequencer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int DUR_W      = 27,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_rgb,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              loop,
  input  logic              go,
  input  logic              stop,
  input  logic              trigger_next,
  output logic [2:0]        rgb,
  output logic [DUR_W-1:0]  pulse_duration_cycles,
  output logic              start,
  output logic              led_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx
);
  import led_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_t        state;
  step_t             wr_step, rd_step;
  logic [ADDR_W-1:0] rd_addr, idx_nxt;
  logic [ADDR_W:0]   steps_eff;
  logic              is_last;
  logic [DUR_W-1:0]  ld_dur;

`ifdef SEQ_GAP_EN
  localparam bit GAP_ON = (GAP_CYCLES > 0);
  localparam int GCW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  logic [GCW-1:0] gap_cnt;
`else
  localparam int unused_gap_cycles = GAP_CYCLES;
`endif

  assign wr_step.rgb = wr_rgb;
  assign wr_step.dur = wr_dur;

  led_step_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_step),
    .rd_addr (rd_addr),
    .rd_data (rd_step)
  );

  // "Last" compares against the live num_steps, so mid-play changes apply at the next trigger.
  assign steps_eff = (num_steps > DEPTH_L) ? DEPTH_L : num_steps;
  assign is_last   = ({1'b0, step_idx} + (ADDR_W+1)'(1)) >= steps_eff;

  // Read address is the entry about to be launched on this edge.
  always_comb begin
    idx_nxt = is_last ? '0 : step_idx + ADDR_W'(1);
    case (state)
      IDLE:    rd_addr = '0;
      WAIT:    rd_addr = idx_nxt;
      default: rd_addr = step_idx;
    endcase
    ld_dur = (rd_step.dur == '0) ? DUR_W'(1) : rd_step.dur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      rgb                   <= '0;
      pulse_duration_cycles <= '0;
      start                 <= 1'b0;
      led_rst               <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      step_idx              <= '0;
`ifdef SEQ_GAP_EN
      gap_cnt               <= '0;
`endif
    end else begin
      start   <= 1'b0;
      led_rst <= 1'b0;
      done    <= 1'b0;
      if (stop && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        rgb     <= '0;
        led_rst <= 1'b1;
      end else begin
        case (state)
          IDLE: if (go && !stop) begin
            if (num_steps == '0) begin
              done <= 1'b1;
            end else begin
              state                 <= LAUNCH;
              busy                  <= 1'b1;
              step_idx              <= '0;
              rgb                   <= rd_step.rgb;
              pulse_duration_cycles <= ld_dur;
              start                 <= 1'b1;
            end
          end
          LAUNCH: state <= WAIT;
          WAIT: if (trigger_next) begin
            if (is_last && !loop) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step_idx <= idx_nxt;
`ifdef SEQ_GAP_EN
              if (GAP_ON) begin
                state   <= GAP;
                rgb     <= '0;
                gap_cnt <= GCW'(GAP_CYCLES - 1);
              end else begin
                state                 <= LAUNCH;
                rgb                   <= rd_step.rgb;
                pulse_duration_cycles <= ld_dur;
                start                 <= 1'b1;
              end
`else
              state                 <= LAUNCH;
              rgb                   <= rd_step.rgb;
              pulse_duration_cycles <= ld_dur;
              start                 <= 1'b1;
`endif
            end
          end
`ifdef SEQ_GAP_EN
          GAP: begin
            if (gap_cnt == '0) begin
              state                 <= LAUNCH;
              rgb                   <= rd_step.rgb;
              pulse_duration_cycles <= ld_dur;
              start                 <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - GCW'(1);
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer; a behavioural controller model answers each start
// with trigger_next after the programmed duration. Build with SEQ_GAP_EN to match a gap build.
module tb_led_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 27;
`ifdef SEQ_GAP_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 1;
`endif

  logic          clk = 0, rst = 1;
  logic          wr_en = 0, loop = 0, go = 0, stop = 0, trigger_next;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_rgb = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   num_steps = '0;
  logic [2:0]    rgb;
  logic [DW-1:0] pulse_duration_cycles;
  logic          start, led_rst, busy, done;
  logic [AW-1:0] step_idx;

  led_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DUR_W(DW), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .wr_dur(wr_dur), .num_steps(num_steps), .loop(loop), .go(go), .stop(stop),
    .trigger_next(trigger_next), .rgb(rgb), .pulse_duration_cycles(pulse_duration_cycles),
    .start(start), .led_rst(led_rst), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // kind: 0 start, 1 done, 2 led_rst
  typedef struct { int kind; int idx; int rgb; int dur; bit sp; } ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_trig = -100;
  int start_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input int r, input int d, input bit sp);
    ev_t e;
    e.kind = kind; e.idx = idx; e.rgb = r; e.dur = d; e.sp = sp;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none", kind);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) begin
        chk("start_idx", step_idx, e.idx);
        chk("start_rgb", rgb, e.rgb);
        chk("start_dur", pulse_duration_cycles, e.dur);
        if (e.sp) chk("trig_to_start", cyc - last_trig, SPACING);
      end
    end
  endtask

  // Controller model: trigger_next pulses in the cycle 'dur' cycles after start.
  initial begin
    int cnt;
    cnt = 0;
    trigger_next = 0;
    forever begin
      @(posedge clk); #2;
      trigger_next = 0;
      if (rst || led_rst) cnt = 0;
      else if (start) cnt = int'(pulse_duration_cycles);
      else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) trigger_next = 1;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (trigger_next) last_trig = cyc;
`ifdef SEQ_GAP_EN
        if (busy && !start && cyc == last_trig + 2) chk("gap_rgb_dark", rgb, 0);
`endif
        if (start)   begin take(0); start_cnt++; end
        if (done)    begin take(1); done_cnt++;  end
        if (led_rst) take(2);
      end
    end
  end

  task automatic write_entry(input int a, input int r, input int d);
    @(posedge clk); #1;
    wr_en = 1; wr_addr = AW'(a); wr_rgb = 3'(r); wr_dur = DW'(d);
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic pulse(input bit g, input bit s);
    @(posedge clk); #1;
    go = g; stop = s;
    @(posedge clk); #1;
    go = 0; stop = 0;
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (start_cnt < target && n < 500) begin @(negedge clk); n++; end
    if (start_cnt < target) begin
      checks++; errors++;
      $display("FAIL timeout_starts actual=%0d required=%0d", start_cnt, target);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin @(negedge clk); n++; end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL timeout_done actual=%0d required=%0d", done_cnt, target);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_dur", pulse_duration_cycles, 0);
    chk("rst_start", start, 0);
    chk("rst_led_rst", led_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_idx", step_idx, 0);
    @(posedge clk); #1 rst = 0;

    // One-shot three steps
    write_entry(0, 3'b101, 10);
    write_entry(1, 3'b010, 5);
    write_entry(2, 3'b111, 3);
    num_steps = 3; loop = 0;
    push(0, 0, 3'b101, 10, 0);
    push(0, 1, 3'b010, 5, 1);
    push(0, 2, 3'b111, 3, 1);
    push(1, 0, 0, 0, 0);
    pulse(1, 0);
    wait_done(1);
    @(negedge clk);
    chk("oneshot_busy_after", busy, 0);
    chk("oneshot_queue_empty", q.size(), 0);

    // Looping two steps, then stop
    num_steps = 2; loop = 1;
    push(0, 0, 3'b101, 10, 0);
    push(0, 1, 3'b010, 5, 1);
    push(0, 0, 3'b101, 10, 1);
    push(0, 1, 3'b010, 5, 1);
    push(0, 0, 3'b101, 10, 1);
    pulse(1, 0);
    wait_starts(start_cnt + 5 - (start_cnt - 3));
    wait_starts(8);
    push(2, 0, 0, 0, 0);
    pulse(0, 1);
    @(negedge clk);
    chk("loop_stop_busy", busy, 0);
    repeat (30) @(posedge clk);
    chk("loop_queue_empty", q.size(), 0);

    // Stop during WAIT of step 1
    num_steps = 3; loop = 0;
    push(0, 0, 3'b101, 10, 0);
    push(0, 1, 3'b010, 5, 1);
    pulse(1, 0);
    wait_starts(10);
    repeat (2) @(posedge clk);
    push(2, 0, 0, 0, 0);
    pulse(0, 1);
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_rgb", rgb, 0);
    repeat (30) @(posedge clk);
    chk("stop_no_more_events", q.size(), 0);

    // num_steps==0, then go & stop together
    num_steps = 0;
    push(1, 0, 0, 0, 0);
    pulse(1, 0);
    wait_done(2);
    num_steps = 3;
    pulse(1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("go_stop_busy", busy, 0);
    chk("go_stop_no_events", q.size(), 0);

    // Zero duration driven as 1; rewrite entry 2 while step 0 plays
    write_entry(0, 3'b011, 8);
    write_entry(1, 3'b100, 0);
    write_entry(2, 3'b110, 4);
    num_steps = 3; loop = 0;
    push(0, 0, 3'b011, 8, 0);
    push(0, 1, 3'b100, 1, 1);
    pulse(1, 0);
    wait_starts(11);
    write_entry(2, 3'b001, 2);
    push(0, 2, 3'b001, 2, 1);
    push(1, 0, 0, 0, 0);
    wait_done(3);
    @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
